arinc_frame_scanner: RTL
========================

// Module: arinc_frame_scanner
// PURPOSE
//  Downstream consumer of the six-channel ARINC429 receive RAMs (6 x 32 x 16b).
//  On each frame strobe, walks every channel and word address and reads the RAMs.
//  Presents each word as a tagged valid/ready stream to the FDAU frame packer.
//  One scan is in flight at a time; a strobe arriving during a scan is flagged, not queued.
// PARAMETERS
//  N_CH    6   number of ARINC channels scanned
//  WORDS   32  words per channel RAM
//  ADDR_W  5   RAM read address width, log2(WORDS)
//  DATA_W  16  RAM word width
//  RD_LAT  2   RAM read latency in clocks, from address driven to q valid; legal range 1..3
// PORTS
//  clock        in   1              system clock (400 kHz domain)
//  reset        in   1              asynchronous, active-low reset
//  start        in   1              frame strobe, one-clock pulse
//  overrun_clr  in   1              clears the overrun flag
//  rd_addr      out  ADDR_W         read address, broadcast to all rd_arincN
//  arinc_q      in   N_CH*DATA_W    RAM outputs; channel k occupies [k*DATA_W +: DATA_W]
//  out_data     out  DATA_W         stream word
//  out_ch       out  3              stream channel index, 0..N_CH-1
//  out_addr     out  ADDR_W         stream word address
//  out_valid    out  1              stream valid
//  out_ready    in   1              stream ready from the consumer
//  busy         out  1              scan in progress
//  done         out  1              one-clock pulse at end of scan
//  overrun      out  1              sticky: start arrived while not IDLE
// BEHAVIOUR
//  Reset values: every output is 0; FSM is in IDLE; ch = 0; addr = 0.
//  Reset is asynchronous and active-low, and is honoured in any state, including mid-scan and mid-handshake.
//  FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
//   IDLE  -> ISSUE when start=1. ch and addr are loaded with 0.
//   ISSUE -> WAIT. rd_addr is driven with addr and the latency counter is loaded with RD_LAT-1.
//            rd_addr is held stable until the next ISSUE.
//   WAIT  -> HOLD when the counter reaches 0. On that edge, arinc_q[ch] is captured into out_data,
//            and out_ch/out_addr are loaded.
//   HOLD  -> out_valid=1. Data and tags are held stable until out_valid & out_ready.
//            On the handshake: if addr == WORDS-1, then addr wraps to 0 and ch increments.
//            Otherwise addr increments. Next state is ISSUE, or DONE after ch N_CH-1 / addr WORDS-1.
//   DONE  -> done=1 for exactly one clock, then IDLE.
//  busy = 1 in ISSUE, WAIT, HOLD and DONE.
//  out_valid is never deasserted before the handshake completes.
//  Minimum per-word cost with out_ready tied high is RD_LAT+2 clocks.
//   With RD_LAT=2, one full scan of 192 words takes 192*4 + 1 = 769 clocks from start to done.
//  start in any state other than IDLE, including DONE, is ignored and sets overrun.
//  overrun_clr clears overrun. If overrun_clr and a set event occur in the same clock, set wins.
//  Counter widths are exact (ch: 3b, addr: ADDR_W). No arithmetic beyond the increment and wrap described above.
// CONFIGURATION
//  ARINC_SKIP_ZERO_EN defined:
//   A captured word equal to 16'h0000 (empty slot) skips HOLD; the FSM advances directly to ISSUE or DONE.
//   No handshake occurs for that word and out_valid stays 0.
//   A scan in which every word is zero still produces the done pulse.
//  ARINC_SKIP_ZERO_EN undefined:
//   Every one of the N_CH*WORDS words is presented, including zero words.
// STRUCTURE
//  Shared package arinc_pkg:
//   N_CH, WORDS, ADDR_W and DATA_W constants, the FSM state encoding, and the channel-index width.
//  One sub-module: arinc_word_mux, a combinational N_CH:1 DATA_W selector of arinc_q by ch.
//  The FSM, counters and output register stay in this module.
// TESTING
//  1. Reset low mid-HOLD (out_valid=1) -> all outputs 0 asynchronously; FSM in IDLE after release.
//  2. RAM model where word = {ch[2:0], 3'b0, addr[4:0], 5'b0}, out_ready=1, start pulse
//     -> 192 words in order ch0/a0 .. ch5/a31 with matching data; done pulse at clock 769.
//  3. out_ready toggling pseudo-randomly -> out_data/out_ch/out_addr stable while out_valid & !out_ready;
//     no word is lost or duplicated.
//  4. Second start issued at clock 100 of a scan -> overrun=1; scan completes normally;
//     overrun_clr clears the flag; overrun_clr coincident with a start during busy -> overrun stays 1.
//  5. Boundaries -> ch1/a31 is followed by ch2/a0; ch5/a31 handshake -> DONE then IDLE;
//     start exactly in the DONE cycle -> overrun=1 and no new scan.
//  6. ARINC_SKIP_ZERO_EN with only ch3/a7 = 16'hA5A5 nonzero -> exactly one stream word (ch 3, addr 7),
//     then the done pulse; without the macro -> 192 words.

Source files
------------

// File: rtl/arinc_pkg.sv
// Shared constants and FSM encoding for the ARINC429 receive-RAM frame scanner.
package arinc_pkg;

    localparam int unsigned N_CH   = 6;
    localparam int unsigned WORDS  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned LAT_W  = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/arinc_word_mux.sv
// Combinational N_CH:1 selector picking one channel's RAM output word.
module arinc_word_mux
    import arinc_pkg::*;
(
    input  logic [N_CH*DATA_W-1:0] arinc_q,
    input  logic [CH_W-1:0]        ch,
    output logic [DATA_W-1:0]      word
);

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (ch == CH_W'(k)) begin
                word = arinc_q[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/arinc_frame_scanner.sv
// Walks all ARINC channel RAMs once per frame strobe and streams each word with its tags.
// Optional build macro ARINC_SKIP_ZERO_EN: zero words are dropped instead of presented.
module arinc_frame_scanner
    import arinc_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   overrun_clr,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [N_CH*DATA_W-1:0] arinc_q,
    output logic [DATA_W-1:0]      out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic [ADDR_W-1:0]      out_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] sel_word;
    logic [CH_W-1:0]   ch_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              last_word;
    logic              skip_word;

    arinc_word_mux u_mux (
        .arinc_q (arinc_q),
        .ch      (ch_q),
        .word    (sel_word)
    );

`ifdef ARINC_SKIP_ZERO_EN
    assign skip_word = (sel_word == '0);
`else
    assign skip_word = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        addr_d     = addr_q;
        lat_d      = lat_q;
        rd_addr_d  = rd_addr_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_addr_d = out_addr_q;

        last_word = (ch_q == CH_W'(N_CH - 1)) && (addr_q == ADDR_W'(WORDS - 1));
        if (addr_q == ADDR_W'(WORDS - 1)) begin
            addr_nxt = '0;
            ch_nxt   = ch_q + 1'b1;
        end else begin
            addr_nxt = addr_q + 1'b1;
            ch_nxt   = ch_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ch_d    = '0;
                    addr_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_addr_d = addr_q;
                lat_d     = LAT_W'(RD_LAT - 1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    // Skipped words advance the walk here, leaving the output register untouched.
                    if (skip_word) begin
                        ch_d    = ch_nxt;
                        addr_d  = addr_nxt;
                        state_d = last_word ? ST_DONE : ST_ISSUE;
                    end else begin
                        out_data_d = sel_word;
                        out_ch_d   = ch_q;
                        out_addr_d = addr_q;
                        state_d    = ST_HOLD;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    ch_d    = ch_nxt;
                    addr_d  = addr_nxt;
                    state_d = last_word ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A set in the same clock as a clear must win.
        overrun_d = (start && (state_q != ST_IDLE)) || (overrun_q && !overrun_clr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            addr_q     <= '0;
            lat_q      <= '0;
            rd_addr_q  <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_addr_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            addr_q     <= addr_d;
            lat_q      <= lat_d;
            rd_addr_q  <= rd_addr_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_addr_q <= out_addr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_addr  = out_addr_q;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign overrun   = overrun_q;

endmodule
